regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port among N_REQ writeback requesters (ALU, load unit, mul/div) using round-robin arbitration and a valid/ready handshake.
- Holds a per-register busy scoreboard: a bit is set when an instruction with destination rd issues, and cleared when that register's write reaches the register file.
- Decode reads the scoreboard to stall on RAW hazards.
- Sits between the execute-stage units and the register file write port (reg_write, rd_addr, rd_data).

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback path.
package regfile_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NUM_REGS = 2 ** AW;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port plus the RAW busy scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = regfile_pkg::XLEN,
  parameter int unsigned AW    = regfile_pkg::AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        wb_valid,
  input  logic [N_REQ*AW-1:0]     wb_addr,
  input  logic [N_REQ*XLEN-1:0]   wb_data,
  output logic [N_REQ-1:0]        wb_ready,
  output logic                    reg_write,
  output logic [AW-1:0]           rd_addr,
  output logic [XLEN-1:0]         rd_data,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    flush
);
  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NREGS = 2 ** AW;

  logic [PW-1:0]    last_q, last_d;
  logic             reg_write_q, reg_write_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic             xfer;
  logic [PW-1:0]    gnt_idx;
  logic [AW-1:0]    sel_addr;
  logic [XLEN-1:0]  sel_data;

  // Flush withholds every grant so nothing is consumed that cycle.
  assign arb_req = flush ? '0 : wb_valid;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req (arb_req),
    .ptr (last_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        sel_addr = wb_addr[i*AW +: AW];
        sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
    xfer = |gnt;
  end

  always_comb begin
    last_d      = xfer ? gnt_idx : last_q;
    reg_write_d = xfer && (sel_addr != '0);
    rd_addr_d   = reg_write_d ? sel_addr : rd_addr_q;
    rd_data_d   = reg_write_d ? sel_data : rd_data_q;

    // Clear on write, then set on issue so a same-cycle re-issue stays pending.
    busy_d = busy_q;
    if (reg_write_q) busy_d[rd_addr_q] = 1'b0;
    if (iss_valid)   busy_d[iss_rd]    = 1'b1;
    if (flush)       busy_d            = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= PW'(N_REQ - 1);
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_ready  = gnt;
  assign reg_write = reg_write_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign rs1_busy  = busy_q[rs1_addr];
  assign rs2_busy  = busy_q[rs2_addr];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios, then random traffic.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic      we;
    reg_addr_t a;
    xlen_t     d;
  } wr_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        wb_valid;
  logic [N*AW-1:0]     wb_addr;
  logic [N*XLEN-1:0]   wb_data;
  logic [N-1:0]        wb_ready;
  logic                reg_write;
  reg_addr_t           rd_addr;
  xlen_t               rd_data;
  logic                iss_valid;
  reg_addr_t           iss_rd;
  reg_addr_t           rs1_addr;
  reg_addr_t           rs2_addr;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                flush;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  wr_t   exp_q[$];
  wr_t   cur_out;
  int    last_m;
  bit    busy_m [NUM_REGS];
  logic  pv [N];
  reg_addr_t pa [N];
  xlen_t pd [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs, advance the reference model.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*XLEN-1:0] d,
                       input logic iv, input reg_addr_t ird, input reg_addr_t r1, input reg_addr_t r2,
                       input logic fl, output int g);
    wr_t nx;
    @(posedge clk);
    #1;
    wb_valid = v; wb_addr = a; wb_data = d;
    iss_valid = iv; iss_rd = ird; rs1_addr = r1; rs2_addr = r2; flush = fl;
    #1;
    g = -1;
    if (!fl) begin
      for (int k = 1; k <= int'(N); k++) begin
        int idx;
        idx = (last_m + k) % int'(N);
        if (g < 0 && v[idx]) g = idx;
      end
    end
    check("wb_ready", 64'(wb_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    check("rs1_busy", 64'(rs1_busy), 64'(busy_m[r1]));
    check("rs2_busy", 64'(rs2_busy), 64'(busy_m[r2]));
    nx = '0;
    if (g >= 0 && a[g*AW +: AW] != '0) begin
      nx.we = 1'b1;
      nx.a  = a[g*AW +: AW];
      nx.d  = d[g*XLEN +: XLEN];
    end
    if (cur_out.we) busy_m[cur_out.a] = 1'b0;
    if (iv && ird != '0) busy_m[ird] = 1'b1;
    if (fl) foreach (busy_m[i]) busy_m[i] = 1'b0;
    if (g >= 0) last_m = g;
    exp_q.push_back(nx);
    cur_out = nx;
  endtask

  // Monitor: every cycle the write port must match the oldest expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("reg_write", 64'(reg_write), 64'(e.we));
          if (e.we) begin
            check("rd_addr", 64'(rd_addr), 64'(e.a));
            check("rd_data", 64'(rd_data), 64'(e.d));
          end
        end
      end
    end
  end

  initial begin
    int g;
    reset = 1'b1; wb_valid = '0; wb_addr = '0; wb_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0; flush = 1'b0;
    last_m = int'(N) - 1;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    foreach (pv[i]) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_reg_write", 64'(reg_write), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_ready", 64'(wb_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cur_out = '0;
    exp_q.push_back('0);
    mon_en = 1'b1;

    // Single write from requester 0.
    cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, '0, '0, '0, 1'b0, g);
    // All three requesting back to back.
    repeat (4)
      cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001},
            1'b0, '0, '0, '0, 1'b0, g);
    // Busy on issue, cleared the cycle after the write lands.
    cycle(3'b000, '0, '0, 1'b1, 5'd7, 5'd7, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd7, '0, 1'b0, g);
    cycle(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h0000_7777}, 1'b0, '0, 5'd7, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd7, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd7, '0, 1'b0, g);
    // Re-issue to a register in the same cycle its write lands: stays busy.
    cycle(3'b000, '0, '0, 1'b1, 5'd9, '0, 5'd9, 1'b0, g);
    cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h0000_9999}, 1'b0, '0, 5'd9, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b1, 5'd9, 5'd9, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd9, 5'd9, 1'b0, g);
    // Writes and issues to x0.
    cycle(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234_5678}, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd0, 5'd0, 1'b0, g);
    // Flush clears busy and blocks the grant for one cycle.
    cycle(3'b000, '0, '0, 1'b1, 5'd3, '0, '0, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b1, 5'd4, 5'd3, '0, 1'b0, g);
    cycle(3'b010, {5'd0, 5'd12, 5'd0}, {32'd0, 32'h0C0C_0C0C, 32'd0}, 1'b0, '0, 5'd3, 5'd4, 1'b1, g);
    cycle(3'b010, {5'd0, 5'd12, 5'd0}, {32'd0, 32'h0C0C_0C0C, 32'd0}, 1'b0, '0, 5'd3, 5'd4, 1'b0, g);
    cycle(3'b000, '0, '0, 1'b0, '0, 5'd9, 5'd12, 1'b0, g);

    // Random traffic; requesters hold their payload until granted.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0]      v;
      logic [N*AW-1:0]   a;
      logic [N*XLEN-1:0] d;
      for (int i = 0; i < int'(N); i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pa[i] = AW'($urandom_range(0, 7));
          pd[i] = $urandom;
        end
        v[i] = pv[i];
        a[i*AW +: AW] = pa[i];
        d[i*XLEN +: XLEN] = pd[i];
      end
      cycle(v, a, d, 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 15) == 0), g);
      if (g >= 0) pv[g] = 1'b0;
    end

    // Async reset while a write is on the port drops it immediately.
    cycle(3'b001, {5'd0, 5'd0, 5'd6}, {32'd0, 32'd0, 32'h600D_F00D}, 1'b0, '0, '0, '0, 1'b0, g);
    @(posedge clk);
    #1;
    wb_valid = '0; iss_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("pre_reset_write", 64'(reg_write), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_reg_write", 64'(reg_write), 64'd0);
    check("async_reset_rd_addr", 64'(rd_addr), 64'd0);
    check("async_reset_rd_data", 64'(rd_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
